dtc_rx: RTL

//  SRU-side receiver for the DTC return link driven by the FEE transmitter.

---
 rtl/dtc_rx_pkg.sv | 32 +++
 rtl/dtc_rx_align.sv | 72 +++++++
 rtl/dtc_rx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dtc_rx_pkg.sv
// Shared definitions for the DTC return-link receiver: link control words
// (the FEE transmitter uses the same values) and the frame FSM state type.
package dtc_rx_pkg;

   localparam logic [15:0] SYNC_WORD  = 16'hBC50;
   localparam logic [15:0] REPLY_HDR  = 16'hF7F7;
   localparam logic [15:0] STATUS_HDR = 16'hDCDC;
   localparam logic [15:0] EVENT_HDR  = 16'h5C5C;
   localparam logic [15:0] END_WORD   = 16'hC5D5;
   localparam logic [15:0] FILL_WORD  = 16'h8012;

   typedef enum logic [3:0] {
      ST_UNLOCK,
      ST_IDLE,
      ST_RPL_AH,
      ST_RPL_AL,
      ST_RPL_DH,
      ST_RPL_DL,
      ST_STS,
      ST_EVT_LO,
      ST_EVT_HI,
      ST_EVT_END1,
      ST_EVT_END2
   } rx_state_t;

   // Words that are legal while the link is idle (sync or a frame header).
   function automatic logic is_idle_word(input logic [15:0] w);
      return (w == SYNC_WORD) || (w == REPLY_HDR) ||
             (w == STATUS_HDR) || (w == EVENT_HDR);
   endfunction

endpackage

// File: rtl/dtc_rx_align.sv
// Word alignment for the DTC return link: shifts in 4 link bits per cycle,
// free-runs a 2-bit phase counter and locks onto the phase at which the sync
// word repeatedly appears. Lock is released only on request from the FSM.
module dtc_rx_align
   import dtc_rx_pkg::*;
#(
   parameter int LOCK_MATCHES = 2
) (
   input  logic        rdoclk,
   input  logic        reset_n,
   input  logic [3:0]  dtc_nib,
   input  logic        unlock_req,
   output logic [15:0] word,
   output logic        word_stb,
   output logic        locked
);

   localparam logic [7:0] LOCK_N = 8'(LOCK_MATCHES);

   logic [15:0] sh_p0;
   logic [1:0]  phase;
   logic [1:0]  cand_phase;
   logic [1:0]  lock_phase;
   logic [7:0]  hit_cnt;
   logic [7:0]  hit_next;
   logic        hit;

   assign hit      = (sh_p0 == SYNC_WORD);
   assign word     = sh_p0;
   assign word_stb = locked && (phase == lock_phase);

   // Hit count if the current sync hit is taken: continue a run only at the candidate phase.
   always_comb begin
      hit_next = 8'd1;
      if ((hit_cnt != 8'd0) && (phase == cand_phase))
         hit_next = hit_cnt + 8'd1;
   end

   // Nibble shifter, phase counter and lock acquisition/release.
   always_ff @(posedge rdoclk) begin
      if (!reset_n) begin
         sh_p0      <= '0;
         phase      <= '0;
         cand_phase <= '0;
         lock_phase <= '0;
         hit_cnt    <= '0;
         locked     <= 1'b0;
      end else begin
         sh_p0 <= {dtc_nib, sh_p0[15:4]};
         phase <= phase + 2'd1;
         if (locked) begin
            if (unlock_req) begin
               locked  <= 1'b0;
               hit_cnt <= '0;
            end
         end else if (hit) begin
            cand_phase <= phase;
            if (hit_next >= LOCK_N) begin
               locked     <= 1'b1;
               lock_phase <= phase;
               hit_cnt    <= '0;
            end else begin
               hit_cnt <= hit_next;
            end
         end else if (phase == cand_phase) begin
            // the run must be consecutive: a miss at the candidate phase restarts it
            hit_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/dtc_rx.sv
// DTC return-link receiver (SRU side). Aligns the 4-bit link stream to 16-bit
// words, parses reply, status and event frames, and presents registered
// single-cycle pulses and holding buses to the readout logic.
module dtc_rx
   import dtc_rx_pkg::*;
#(
   parameter int LOCK_MATCHES = 2,
   parameter int UNLOCK_ERRS  = 4,
   parameter int CNT_W        = 16
) (
   input  logic             rdoclk,
   input  logic             reset_n,
   input  logic [3:0]       dtc_nib,
   input  logic             CntRst,
   output logic             locked,
   output logic             reply_valid,
   output logic [31:0]      reply_addr,
   output logic [31:0]      reply_data,
   output logic             status_valid,
   output logic [15:0]      fee_status,
   output logic             evt_wr,
   output logic [31:0]      evt_data,
   output logic             evt_last,
   output logic             evt_end,
   output logic             evt_abort,
   output logic             frame_err,
   output logic [CNT_W-1:0] event_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_ERRS - 1);

   logic [15:0] word;
   logic        word_stb;
   logic        unlock_req;
   rx_state_t   state;
   logic [7:0]  bad_cnt;
   logic [15:0] addr_hi_p0;
   logic [15:0] addr_lo_p0;
   logic [15:0] data_hi_p0;
   logic [15:0] evt_lo_p0;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   dtc_rx_align #(
      .LOCK_MATCHES (LOCK_MATCHES)
   ) u_align (
      .rdoclk     (rdoclk),
      .reset_n    (reset_n),
      .dtc_nib    (dtc_nib),
      .unlock_req (unlock_req),
      .word       (word),
      .word_stb   (word_stb),
      .locked     (locked)
   );

   // The last tolerated bad idle word drops lock on the same edge the FSM leaves IDLE.
   assign unlock_req = (state == ST_IDLE) && word_stb && !is_idle_word(word) &&
                       (bad_cnt == UNLOCK_LAST);

   // Frame FSM with registered pulses, holding buses and counters.
   always_ff @(posedge rdoclk) begin
      if (!reset_n) begin
         state        <= ST_UNLOCK;
         bad_cnt      <= '0;
         addr_hi_p0   <= '0;
         addr_lo_p0   <= '0;
         data_hi_p0   <= '0;
         evt_lo_p0    <= '0;
         reply_valid  <= 1'b0;
         reply_addr   <= '0;
         reply_data   <= '0;
         status_valid <= 1'b0;
         fee_status   <= '0;
         evt_wr       <= 1'b0;
         evt_data     <= '0;
         evt_last     <= 1'b0;
         evt_end      <= 1'b0;
         evt_abort    <= 1'b0;
         frame_err    <= 1'b0;
         event_cnt    <= '0;
         err_cnt      <= '0;
      end else begin
         reply_valid  <= 1'b0;
         status_valid <= 1'b0;
         evt_wr       <= 1'b0;
         evt_last     <= 1'b0;
         evt_end      <= 1'b0;
         evt_abort    <= 1'b0;
         frame_err    <= 1'b0;

         // counters follow the registered pulses; a clear wins over a same-cycle count
         if (CntRst) begin
            event_cnt <= '0;
            err_cnt   <= '0;
         end else begin
            if (evt_end)
               event_cnt <= event_cnt + 1'b1;
            if (frame_err)
               err_cnt <= sat_inc(err_cnt);
         end

         if (!locked) begin
            state   <= ST_UNLOCK;
            bad_cnt <= '0;
         end else if (state == ST_UNLOCK) begin
            state <= ST_IDLE;
         end else if (word_stb) begin
            case (state)
               ST_IDLE: begin
                  if (word == REPLY_HDR) begin
                     state   <= ST_RPL_AH;
                     bad_cnt <= '0;
                  end else if (word == STATUS_HDR) begin
                     state   <= ST_STS;
                     bad_cnt <= '0;
                  end else if (word == EVENT_HDR) begin
                     state   <= ST_EVT_LO;
                     bad_cnt <= '0;
                  end else if (word == SYNC_WORD) begin
                     bad_cnt <= '0;
                  end else begin
                     frame_err <= 1'b1;
                     if (bad_cnt == UNLOCK_LAST) begin
                        state   <= ST_UNLOCK;
                        bad_cnt <= '0;
                     end else begin
                        bad_cnt <= bad_cnt + 8'd1;
                     end
                  end
               end
               ST_RPL_AH: begin
                  addr_hi_p0 <= word;
                  state      <= ST_RPL_AL;
               end
               ST_RPL_AL: begin
                  addr_lo_p0 <= word;
                  state      <= ST_RPL_DH;
               end
               ST_RPL_DH: begin
                  data_hi_p0 <= word;
                  state      <= ST_RPL_DL;
               end
               ST_RPL_DL: begin
                  reply_valid <= 1'b1;
                  reply_addr  <= {addr_hi_p0, addr_lo_p0};
                  reply_data  <= {data_hi_p0, word};
                  state       <= ST_IDLE;
               end
               ST_STS: begin
                  status_valid <= 1'b1;
                  fee_status   <= word;
                  state        <= ST_IDLE;
               end
               ST_EVT_LO: begin
                  evt_lo_p0 <= word;
                  state     <= ST_EVT_HI;
               end
               ST_EVT_HI: begin
                  if ((word == FILL_WORD) && (evt_lo_p0 == FILL_WORD)) begin
                     state <= ST_EVT_LO;
                  end else if ((word == END_WORD) && (evt_lo_p0 == END_WORD)) begin
                     // end words with no trailer seen: FEE readout timed out
                     evt_abort <= 1'b1;
                     evt_end   <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     evt_wr   <= 1'b1;
                     evt_data <= {word, evt_lo_p0};
                     if (word[15:14] == 2'b11) begin
                        evt_last <= 1'b1;
                        state    <= ST_EVT_END1;
                     end else begin
                        state <= ST_EVT_LO;
                     end
                  end
               end
               ST_EVT_END1: begin
                  if (word == END_WORD) begin
                     state <= ST_EVT_END2;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= ST_IDLE;
                  end
               end
               ST_EVT_END2: begin
                  if (word == END_WORD)
                     evt_end <= 1'b1;
                  else
                     frame_err <= 1'b1;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
